// File: rtl/mem_wait_ram.sv
// Word-organised RAM with a programmable number of wait states and a
// four-phase MOV/MOC handshake. Byte lanes are big-endian.
//
// Ports:
//   Clk      - single clock, rising edge active
//   Reset    - asynchronous active-high reset
//   Enable   - chip select; dropping it aborts an access still waiting
//   MOV      - request, held by the master until MOC is seen
//   RW       - 1 = read, 0 = write
//   Size     - 00 byte, 01 halfword, 10 word, 11 reserved (error)
//   SignExt  - read extension: 1 sign-extend, 0 zero-extend
//   Address  - byte address
//   DataIn   - right-justified write data
//   DataOut  - right-justified, extended read data (held until next read)
//   MOC      - one-cycle completion strobe
//   Err      - access error, meaningful only alongside MOC
module mem_wait_ram #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned WAIT   = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Enable,
  input  logic              MOV,
  input  logic              RW,
  input  logic [1:0]        Size,
  input  logic              SignExt,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       DataIn,
  output logic [31:0]       DataOut,
  output logic              MOC,
  output logic              Err
);

  localparam int unsigned DEPTH     = 2 ** (ADDR_W - 2);
  localparam int unsigned IDX_W     = ADDR_W - 2;
  localparam bit          ZERO_WAIT = (WAIT == 0);
  localparam logic [3:0]  WAIT_LOAD = ZERO_WAIT ? 4'd0 : 4'(WAIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_HOLD} state_t;

  state_t              state;
  logic [3:0]          cnt;
  logic                rw_q;
  logic [1:0]          size_q;
  logic                sext_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         din_q;

  logic [31:0]         mem [DEPTH];

  logic                accept_c;
  logic                go_done_c;
  logic                cur_rw;
  logic [1:0]          cur_size;
  logic                cur_sext;
  logic [ADDR_W-1:0]   cur_addr;
  logic [31:0]         cur_din;
  logic [IDX_W-1:0]    cur_idx;
  logic [1:0]          off;
  logic [31:0]         word_c;
  logic [7:0]          byte_c;
  logic [15:0]         half_c;
  logic                err_c;
  logic [3:0]          be_c;
  logic [31:0]         wdata_c;
  logic [31:0]         rdata_c;
  logic                mem_we_c;

  assign accept_c  = (state == S_IDLE) && Enable && MOV;
  // The access happens on the edge that moves the FSM into DONE, so MOC and
  // DataOut appear together in the DONE cycle.
  assign go_done_c = (accept_c && ZERO_WAIT) ||
                     ((state == S_WAIT) && Enable && (cnt == 4'd0));

  // With no wait states the access uses the inputs of the accepting edge.
  assign cur_rw   = (state == S_IDLE) ? RW      : rw_q;
  assign cur_size = (state == S_IDLE) ? Size    : size_q;
  assign cur_sext = (state == S_IDLE) ? SignExt : sext_q;
  assign cur_addr = (state == S_IDLE) ? Address : addr_q;
  assign cur_din  = (state == S_IDLE) ? DataIn  : din_q;
  assign cur_idx  = cur_addr[ADDR_W-1:2];
  assign off      = cur_addr[1:0];

  // Lane decode, error detection and read extraction.
  always_comb begin
    err_c   = 1'b0;
    be_c    = 4'b0000;
    wdata_c = cur_din;
    rdata_c = 32'd0;
    word_c  = mem[cur_idx];
    // Offset 0 is the most significant byte, so shift by (3 - off) bytes.
    byte_c  = 8'(word_c >> {~off, 3'b000});
    half_c  = off[1] ? word_c[15:0] : word_c[31:16];
    case (cur_size)
      2'b00: begin
        be_c    = 4'(4'b1000 >> off);
        wdata_c = {4{cur_din[7:0]}};
        rdata_c = cur_sext ? {{24{byte_c[7]}}, byte_c} : {24'd0, byte_c};
      end
      2'b01: begin
        err_c   = off[0];
        be_c    = off[1] ? 4'b0011 : 4'b1100;
        wdata_c = {2{cur_din[15:0]}};
        rdata_c = cur_sext ? {{16{half_c[15]}}, half_c} : {16'd0, half_c};
      end
      2'b10: begin
        err_c   = (off != 2'b00);
        be_c    = 4'b1111;
        rdata_c = word_c;
      end
      default: err_c = 1'b1;
    endcase
  end

  // Reset in the same cycle as the completing edge suppresses the write.
  assign mem_we_c = go_done_c && !cur_rw && !err_c && !Reset;

  // Memory array: no reset, contents undefined until written.
  always_ff @(posedge Clk) begin
    if (mem_we_c) begin
      if (be_c[0]) mem[cur_idx][7:0]   <= wdata_c[7:0];
      if (be_c[1]) mem[cur_idx][15:8]  <= wdata_c[15:8];
      if (be_c[2]) mem[cur_idx][23:16] <= wdata_c[23:16];
      if (be_c[3]) mem[cur_idx][31:24] <= wdata_c[31:24];
    end
  end

  // Handshake FSM with registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      MOC     <= 1'b0;
      Err     <= 1'b0;
      DataOut <= 32'd0;
      rw_q    <= 1'b0;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      din_q   <= 32'd0;
    end else begin
      MOC <= 1'b0;
      Err <= 1'b0;
      if (go_done_c) begin
        MOC <= 1'b1;
        Err <= err_c;
        if (cur_rw && !err_c) DataOut <= rdata_c;
      end
      case (state)
        S_IDLE: begin
          if (accept_c) begin
            rw_q   <= RW;
            size_q <= Size;
            sext_q <= SignExt;
            addr_q <= Address;
            din_q  <= DataIn;
            cnt    <= WAIT_LOAD;
            state  <= ZERO_WAIT ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!Enable)           state <= S_IDLE;
          else if (cnt == 4'd0)  state <= S_DONE;
          else                   cnt   <= cnt - 4'd1;
        end
        S_DONE: state <= S_HOLD;
        S_HOLD: if (!MOV || !Enable) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wait_ram.sv
// Bench for mem_wait_ram: a WAIT=2 instance driven through a byte-level
// reference memory and a WAIT=0 instance for zero-latency timing.
module tb_mem_wait_ram;

  localparam int unsigned TB_WAIT = 2;

  typedef struct {
    logic        err;
    logic [31:0] dout;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        en, mov, rw, sext;
  logic [1:0]  size;
  logic [8:0]  addr;
  logic [31:0] din, dout;
  logic        moc, err;

  logic        z_en, z_mov, z_rw, z_sext;
  logic [1:0]  z_size;
  logic [8:0]  z_addr;
  logic [31:0] z_din, z_dout;
  logic        z_moc, z_err;

  int checks = 0;
  int errors = 0;

  exp_t        sbq [$];
  logic [7:0]  bmem [512];
  logic [31:0] last_dout;

  mem_wait_ram #(.ADDR_W(9), .WAIT(TB_WAIT)) dut (
    .Clk(clk), .Reset(rst), .Enable(en), .MOV(mov), .RW(rw), .Size(size),
    .SignExt(sext), .Address(addr), .DataIn(din), .DataOut(dout),
    .MOC(moc), .Err(err)
  );

  mem_wait_ram #(.ADDR_W(9), .WAIT(0)) dut_z (
    .Clk(clk), .Reset(rst), .Enable(z_en), .MOV(z_mov), .RW(z_rw),
    .Size(z_size), .SignExt(z_sext), .Address(z_addr), .DataIn(z_din),
    .DataOut(z_dout), .MOC(z_moc), .Err(z_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: memory as individual bytes, lowest address = MSB of word.
  task automatic model_push(input logic r, input logic [1:0] s, input logic x,
                            input logic [8:0] a, input logic [31:0] d);
    exp_t e;
    int   ia;
    logic [31:0] v;
    ia    = int'(a);
    e.err = (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00);
    if (!e.err) begin
      if (r) begin
        if (s == 2'b00) begin
          v = {24'd0, bmem[ia]};
          if (x && v[7]) v[31:8] = 24'hFFFFFF;
        end else if (s == 2'b01) begin
          v = {16'd0, bmem[ia], bmem[ia+1]};
          if (x && v[15]) v[31:16] = 16'hFFFF;
        end else begin
          v = {bmem[ia], bmem[ia+1], bmem[ia+2], bmem[ia+3]};
        end
        last_dout = v;
      end else begin
        if (s == 2'b00) begin
          bmem[ia] = d[7:0];
        end else if (s == 2'b01) begin
          bmem[ia] = d[15:8]; bmem[ia+1] = d[7:0];
        end else begin
          bmem[ia] = d[31:24]; bmem[ia+1] = d[23:16];
          bmem[ia+2] = d[15:8]; bmem[ia+3] = d[7:0];
        end
      end
    end
    e.dout = last_dout;
    sbq.push_back(e);
  endtask

  // One full handshake on the WAIT=2 instance; inputs are scrambled after
  // the accepting edge, MOV is held 'hold' extra cycles after MOC.
  task automatic access(input logic r, input logic [1:0] s, input logic x,
                        input logic [8:0] a, input logic [31:0] d, input int hold);
    exp_t e;
    int   lat;
    @(negedge clk);
    rw = r; size = s; sext = x; addr = a; din = d; en = 1'b1; mov = 1'b1;
    model_push(r, s, x, a, d);
    @(posedge clk);
    lat = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 1) begin
        rw = ~r; size = ~s; sext = ~x; addr = ~a; din = ~d;
      end
      if (moc === 1'b1) begin
        lat = i;
        break;
      end
    end
    e = sbq.pop_front();
    checks++;
    if (lat == 0) begin
      errors++;
      $display("FAIL moc_timeout addr=%h: no MOC within 16 cycles", a);
    end else begin
      checks++;
      if (lat != TB_WAIT + 1) begin
        errors++;
        $display("FAIL latency addr=%h: got %0d want %0d", a, lat, TB_WAIT + 1);
      end
      checks++;
      if (err !== e.err) begin
        errors++;
        $display("FAIL err addr=%h: got %b want %b", a, err, e.err);
      end
      checks++;
      if (dout !== e.dout) begin
        errors++;
        $display("FAIL dout addr=%h: got %h want %h", a, dout, e.dout);
      end
    end
    for (int i = 0; i <= hold; i++) begin
      @(negedge clk);
      checks++;
      if (moc !== 1'b0 || err !== 1'b0) begin
        errors++;
        $display("FAIL single_pulse addr=%h cycle %0d: moc=%b err=%b want 0 0", a, i, moc, err);
      end
    end
    mov = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (moc !== 1'b0 || err !== 1'b0 || dout !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: moc=%b err=%b dout=%h want 0 0 0", moc, err, dout);
    end
    checks++;
    if (z_moc !== 1'b0 || z_err !== 1'b0 || z_dout !== 32'd0) begin
      errors++;
      $display("FAIL reset_state_z: moc=%b err=%b dout=%h want 0 0 0", z_moc, z_err, z_dout);
    end
    rst = 1'b0;
    last_dout = 32'd0;
  endtask

  task automatic test_word;
    access(1'b0, 2'b10, 1'b0, 9'h010, 32'hDEADBEEF, 0);
    access(1'b1, 2'b10, 1'b0, 9'h010, 32'h0, 0);
    checks++;
    if (dout !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL word_read: got %h want deadbeef", dout);
    end
  endtask

  task automatic test_byte_lanes;
    access(1'b0, 2'b00, 1'b0, 9'h011, 32'h0000007F, 0);
    access(1'b1, 2'b10, 1'b0, 9'h010, 32'h0, 0);
    checks++;
    if (dout !== 32'hDE7FBEEF) begin
      errors++;
      $display("FAIL byte_merge: got %h want de7fbeef", dout);
    end
    access(1'b1, 2'b00, 1'b1, 9'h012, 32'h0, 0);
    checks++;
    if (dout !== 32'hFFFFFFBE) begin
      errors++;
      $display("FAIL byte_sext: got %h want ffffffbe", dout);
    end
    access(1'b1, 2'b00, 1'b0, 9'h012, 32'h0, 0);
    checks++;
    if (dout !== 32'h000000BE) begin
      errors++;
      $display("FAIL byte_zext: got %h want 000000be", dout);
    end
    access(1'b0, 2'b10, 1'b0, 9'h014, 32'h80010203, 0);
    access(1'b1, 2'b00, 1'b1, 9'h014, 32'h0, 0);
    access(1'b1, 2'b00, 1'b1, 9'h017, 32'h0, 0);
    access(1'b0, 2'b00, 1'b0, 9'h017, 32'hFFFFFFA5, 0);
    access(1'b1, 2'b10, 1'b0, 9'h014, 32'h0, 0);
  endtask

  task automatic test_halfword;
    access(1'b1, 2'b01, 1'b1, 9'h012, 32'h0, 0);
    checks++;
    if (dout !== 32'hFFFFBEEF) begin
      errors++;
      $display("FAIL half_sext: got %h want ffffbeef", dout);
    end
    access(1'b0, 2'b01, 1'b0, 9'h013, 32'h00001234, 0);
    checks++;
    if (dout !== 32'hFFFFBEEF) begin
      errors++;
      $display("FAIL half_err_dout: got %h want ffffbeef", dout);
    end
    access(1'b1, 2'b10, 1'b0, 9'h010, 32'h0, 0);
    access(1'b0, 2'b01, 1'b0, 9'h010, 32'h0000CAFE, 0);
    access(1'b1, 2'b10, 1'b0, 9'h010, 32'h0, 0);
    access(1'b1, 2'b01, 1'b0, 9'h010, 32'h0, 0);
  endtask

  task automatic test_errors;
    access(1'b1, 2'b11, 1'b0, 9'h010, 32'h0, 0);
    access(1'b1, 2'b10, 1'b0, 9'h012, 32'h0, 0);
    access(1'b0, 2'b10, 1'b0, 9'h011, 32'h12345678, 0);
    access(1'b0, 2'b11, 1'b0, 9'h014, 32'h12345678, 0);
    access(1'b1, 2'b10, 1'b0, 9'h010, 32'h0, 0);
    access(1'b1, 2'b10, 1'b0, 9'h014, 32'h0, 0);
  endtask

  task automatic test_hold;
    access(1'b0, 2'b10, 1'b0, 9'h01C, 32'h55AA55AA, 5);
    access(1'b1, 2'b10, 1'b0, 9'h01C, 32'h0, 0);
    access(1'b0, 2'b00, 1'b0, 9'h01C, 32'h00000011, 3);
    access(1'b1, 2'b10, 1'b0, 9'h01C, 32'h0, 0);
  endtask

  // Abort a write by pulsing Reset (sel=0) or dropping Enable (sel=1) in WAIT.
  task automatic test_abort(input bit sel);
    int pulses;
    access(1'b0, 2'b10, 1'b0, 9'h020, 32'h11223344, 0);
    access(1'b1, 2'b10, 1'b0, 9'h020, 32'h0, 0);
    @(negedge clk);
    rw = 1'b0; size = 2'b10; sext = 1'b0; addr = 9'h020; din = 32'hAAAAAAAA;
    en = 1'b1; mov = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!sel) begin
      #1 rst = 1'b1; mov = 1'b0;
      #1;
      checks++;
      if (moc !== 1'b0 || err !== 1'b0 || dout !== 32'd0) begin
        errors++;
        $display("FAIL async_reset: moc=%b err=%b dout=%h want 0 0 0", moc, err, dout);
      end
      last_dout = 32'd0;
      #1 rst = 1'b0;
    end else begin
      en = 1'b0; mov = 1'b0;
    end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (moc !== 1'b0) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL abort_no_moc sel=%0d: got %0d pulses want 0", sel, pulses);
    end
    en = 1'b1;
    access(1'b1, 2'b10, 1'b0, 9'h020, 32'h0, 0);
    checks++;
    if (dout !== 32'h11223344) begin
      errors++;
      $display("FAIL abort_readback sel=%0d: got %h want 11223344", sel, dout);
    end
  endtask

  task automatic z_access(input logic r, input logic [8:0] a, input logic [31:0] d,
                          input logic [31:0] want);
    exp_t e;
    @(negedge clk);
    z_rw = r; z_size = 2'b10; z_sext = 1'b0; z_addr = a; z_din = d;
    z_en = 1'b1; z_mov = 1'b1;
    e.err = 1'b0; e.dout = want;
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sbq.pop_front();
    checks++;
    if (z_moc !== 1'b1 || z_err !== e.err || z_dout !== e.dout) begin
      errors++;
      $display("FAIL zero_wait_done addr=%h: moc=%b err=%b dout=%h want 1 0 %h",
               a, z_moc, z_err, z_dout, e.dout);
    end
    @(negedge clk);
    checks++;
    if (z_moc !== 1'b0 || z_dout !== e.dout) begin
      errors++;
      $display("FAIL zero_wait_after addr=%h: moc=%b dout=%h want 0 %h",
               a, z_moc, z_dout, e.dout);
    end
    z_mov = 1'b0;
  endtask

  task automatic test_zero_wait;
    z_access(1'b0, 9'h004, 32'h01020304, 32'h0);
    z_access(1'b1, 9'h004, 32'h0, 32'h01020304);
    z_access(1'b0, 9'h008, 32'hF0E0D0C0, 32'h01020304);
    z_access(1'b1, 9'h008, 32'h0, 32'hF0E0D0C0);
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0; mov = 1'b0; rw = 1'b0; size = 2'b00; sext = 1'b0;
    addr = 9'd0; din = 32'd0;
    z_en = 1'b0; z_mov = 1'b0; z_rw = 1'b0; z_size = 2'b00; z_sext = 1'b0;
    z_addr = 9'd0; z_din = 32'd0;
    last_dout = 32'd0;
    test_reset;
    test_word;
    test_byte_lanes;
    test_halfword;
    test_errors;
    test_hold;
    test_abort(1'b0);
    test_abort(1'b1);
    test_zero_wait;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_wait_ram.md
MEM_WAIT_RAM -- requirements
Module: mem_wait_ram

Interface
REQ-001 Parameter ADDR_W, default 9, byte-address width; memory holds 2**(ADDR_W-2) 32-bit words.
REQ-002 Parameter WAIT, default 2, wait-state cycles inserted before each access completes (legal 0..15).
REQ-003 Clk  input  1  single clock; all state changes on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 Enable  input  1  chip select; low aborts any access not yet completed.
REQ-006 MOV  input  1  memory-operation-valid request, held high by master until MOC seen.
REQ-007 RW  input  1  1 = read, 0 = write.
REQ-008 Size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-009 SignExt  input  1  reads only: 1 sign-extends byte/halfword, 0 zero-extends.
REQ-010 Address  input  ADDR_W  byte address.
REQ-011 DataIn  input  32  write data, right-justified (byte in [7:0], halfword in [15:0]).
REQ-012 DataOut  output  32  read data, right-justified and extended.
REQ-013 MOC  output  1  memory-operation-complete strobe, one Clk cycle.
REQ-014 Err  output  1  access error flag, valid only while MOC=1.

Function
REQ-015 FSM states IDLE, WAIT, DONE, HOLD; all outputs registered.
REQ-016 IDLE: at an edge with Enable=1 and MOV=1, latch RW, Size, SignExt, Address, DataIn; go to WAIT (WAIT>0) or DONE (WAIT=0); load wait counter with WAIT-1.
REQ-017 WAIT: counter decrements each edge; at counter=0 go to DONE.
REQ-018 DONE: access performed using latched values; MOC=1 for exactly this one cycle; next state HOLD.
REQ-019 Latency: MOC high in cycle WAIT+1 after the accepting edge (WAIT=0 -> the cycle immediately following).
REQ-020 HOLD: stay until MOV=0 or Enable=0, then IDLE; a new request requires MOV low for at least one edge (four-phase handshake).
REQ-021 Enable=0 in WAIT: return to IDLE, no memory access, MOC stays 0.
REQ-022 Input changes after the accepting edge have no effect on the access in flight.
REQ-023 Byte lanes big-endian: Address[1:0]=0 selects bits [31:24], =3 selects [7:0]; halfword offset 0 selects [31:16], offset 2 selects [15:0].
REQ-024 Word index = Address[ADDR_W-1:2]; every address in range, no wrap logic required.
REQ-025 Write: only the selected lanes of the addressed word change; other lanes preserved.
REQ-026 Read: DataOut updated in DONE with extracted lanes, upper bits filled per SignExt; DataOut holds value until next successful read.
REQ-027 Error: halfword with Address[0]=1, word with Address[1:0]!=0, or Size=11 -> Err=1 with MOC, no memory write, DataOut unchanged.
REQ-028 Err=0 whenever MOC=0.
REQ-029 Memory contents undefined at power-up; no initialisation logic.

Reset
REQ-030 Reset=1 forces state IDLE, MOC=0, Err=0, DataOut=0, wait counter=0, immediately and independent of Clk.
REQ-031 Reset during WAIT aborts the access: no write occurs, no MOC issued.
REQ-032 Reset does not alter memory contents.
REQ-033 After Reset falls, a request is accepted at the first rising edge satisfying REQ-016.

Verification
REQ-034 WAIT=2: word write 0xDEADBEEF @0x010, then word read @0x010 -> MOC high in 3rd cycle after accept each time, DataOut=0xDEADBEEF, Err=0.
REQ-035 Byte write 0x7F @0x011 over word 0xDEADBEEF, word read @0x010 -> 0xDE7FBEEF; byte read @0x012 SignExt=1 -> 0xFFFFFFBE, SignExt=0 -> 0x000000BE.
REQ-036 Halfword read @0x012 of 0xDE7FBEEF, SignExt=1 -> 0xFFFFBEEF; halfword write @0x013 -> MOC=1, Err=1, memory unchanged, DataOut unchanged.
REQ-037 Hold MOV=1 after MOC -> exactly one MOC pulse, no second access; drop MOV one cycle, reassert -> second access accepted.
REQ-038 Write request, Reset pulsed during WAIT -> MOC never rises, outputs 0, word unchanged on readback; likewise Enable=0 during WAIT -> no MOC, no write.
REQ-039 WAIT=0 build: read accepted at edge k -> MOC=1 during cycle k+1 only, DataOut valid same cycle.
